// File: rtl/pmp_pkg.sv
// pmp_pkg: shared types and constants for the PMP checker.
//   pmp_a_e     - address-matching mode held in a pmpcfg A field
//   pmp_acc_e   - access type carried on req_type
//   pmp_state_e - checker FSM states
//   CFG_*       - bit positions inside one 8-bit pmpcfg entry
//   norm_size   - maps the illegal size encoding 2 onto 3 (word)
package pmp_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pmp_a_e;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    EXEC  = 2'd2
  } pmp_acc_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } pmp_state_e;

  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  // size is a last-byte offset; 2 has no legal meaning and is widened to a word
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'd2) ? 2'd3 : s;
  endfunction

endpackage

// File: rtl/pmp_checker_napot.sv
// napot: naturally-aligned power-of-two region match.
//   addr      - first byte of the access
//   addr_n    - byte-granular NAPOT address; trailing ones give the region size
//               (e.g. 0x0000_0FFF = 4 KiB at 0x0)
//   size      - last-byte offset of the access (already normalised)
//   napot_out - 1 when every byte of the access lies inside the region
module napot (
  input  logic [31:0] addr,
  input  logic [31:0] addr_n,
  input  logic [1:0]  size,
  output logic        napot_out
);

  logic [31:0] mask;
  logic [32:0] end33;

  // Isolates the run of trailing ones: these are the in-region offset bits.
  assign mask  = addr_n & ~(addr_n + 32'd1);
  assign end33 = {1'b0, addr} + {31'b0, size};

  // Both the first and the last byte must share the region base; an access
  // that wraps past the top of the address space never matches.
  assign napot_out = !end33[32]
                  && (((addr         ^ addr_n) & ~mask) == 32'd0)
                  && (((end33[31:0]  ^ addr_n) & ~mask) == 32'd0);

endmodule

// File: rtl/pmp_checker.sv
// pmp_checker: sequential PMP checker, one entry evaluated per cycle.
//   clk, rst             - clock, synchronous active-high reset
//   req_valid/req_ready  - request handshake (addr, size, type, mmode)
//   pmpcfg, pmpaddr      - live PMP state, read every SCAN cycle
//   busy                 - scan in progress; PMP CSRs must stay stable
//   resp_valid/resp_ready- response handshake (allow, hit, entry)
//   dbg_state            - current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. req_ready is high only in IDLE. resp_valid is high for the whole
// of RESP and is never dropped before resp_ready; resp_allow/hit/entry are
// registers that do not change while resp_valid is high.
module pmp_checker
  import pmp_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [1:0]               req_size,
  input  logic [1:0]               req_type,
  input  logic                     req_mmode,
  input  logic [8*NUM_ENTRIES-1:0] pmpcfg,
  input  logic [32*NUM_ENTRIES-1:0] pmpaddr,
  output logic                     busy,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_allow,
  output logic                     resp_hit,
  output logic [IDX_W-1:0]         resp_entry,
  output pmp_state_e               dbg_state
);

  pmp_state_e       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  logic [1:0]       type_q;
  logic             mmode_q;
  logic             allow_q;
  logic             hit_q;
  logic [IDX_W-1:0] entry_q;

  // Entry under evaluation, selected from the live CSR vectors.
  logic [IDX_W-1:0] prev_idx;
  logic [7:0]       cfg_cur;
  logic [31:0]      addr_cur;
  logic [31:0]      tor_lo;
  pmp_a_e           a_cur;

  assign prev_idx = (idx_q == '0) ? '0 : (idx_q - IDX_W'(1));
  assign cfg_cur  = pmpcfg[8*int'(idx_q) +: 8];
  assign addr_cur = pmpaddr[32*int'(idx_q) +: 32];
  assign tor_lo   = (idx_q == '0) ? 32'd0 : pmpaddr[32*int'(prev_idx) +: 32];
  assign a_cur    = pmp_a_e'(cfg_cur[CFG_A_HI:CFG_A_LO]);

  // Last byte of the access at 33 bits so a wrap past 0xFFFF_FFFF is visible.
  logic [32:0] end33;
  logic        carry;
  assign end33 = {1'b0, addr_q} + {31'b0, size_q};
  assign carry = end33[32];

  logic tor_match;
  logic na4_match;
  logic napot_match;

  assign tor_match = !carry && (addr_q >= tor_lo) && (end33[31:0] < addr_cur);
  assign na4_match = !carry && (addr_q[31:2] == addr_cur[31:2])
                  && (({1'b0, addr_q[1:0]} + {1'b0, size_q}) <= 3'd3);

  napot u_napot (
    .addr      (addr_q),
    .addr_n    (addr_cur),
    .size      (size_q),
    .napot_out (napot_match)
  );

  logic match;
  always_comb begin
    match = 1'b0;
    unique case (a_cur)
      OFF:     match = 1'b0;
      TOR:     match = tor_match;
      NA4:     match = na4_match;
      NAPOT:   match = napot_match;
      default: match = 1'b0;
    endcase
  end

  logic perm;
  always_comb begin
    perm = 1'b0;
    case (type_q)
      READ:    perm = cfg_cur[CFG_R];
      WRITE:   perm = cfg_cur[CFG_W];
      EXEC:    perm = cfg_cur[CFG_X];
      default: perm = 1'b0;
    endcase
  end

  // Response values captured when the scan ends at this entry. Machine mode
  // bypasses the permission bits unless the entry is locked.
  logic             last_entry;
  logic             allow_d;
  logic             hit_d;
  logic [IDX_W-1:0] entry_d;

  assign last_entry = (idx_q == IDX_W'(NUM_ENTRIES - 1));
  assign hit_d      = match;
  assign entry_d    = match ? idx_q : '0;
  assign allow_d    = match ? ((mmode_q && !cfg_cur[CFG_L]) ? 1'b1 : perm)
                            : mmode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      type_q  <= '0;
      mmode_q <= 1'b0;
      allow_q <= 1'b0;
      hit_q   <= 1'b0;
      entry_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= norm_size(req_size);
            type_q  <= req_type;
            mmode_q <= req_mmode;
            idx_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (match || last_entry) begin
            allow_q <= allow_d;
            hit_q   <= hit_d;
            entry_q <= entry_d;
            state_q <= RESP;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q == SCAN);
  assign resp_valid = (state_q == RESP);
  assign resp_allow = allow_q;
  assign resp_hit   = hit_q;
  assign resp_entry = entry_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pmp_checker.sv
// tb_pmp_checker: directed bench for pmp_checker (NUM_ENTRIES = 16).
module tb_pmp_checker;
  import pmp_pkg::*;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [31:0]    req_addr;
  logic [1:0]     req_size;
  logic [1:0]     req_type;
  logic           req_mmode;
  logic [8*N-1:0] pmpcfg;
  logic [32*N-1:0] pmpaddr;
  logic           busy;
  logic           resp_valid;
  logic           resp_ready;
  logic           resp_allow;
  logic           resp_hit;
  logic [3:0]     resp_entry;
  pmp_state_e     dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  pmp_checker #(.NUM_ENTRIES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_type   (req_type),
    .req_mmode  (req_mmode),
    .pmpcfg     (pmpcfg),
    .pmpaddr    (pmpaddr),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_allow (resp_allow),
    .resp_hit   (resp_hit),
    .resp_entry (resp_entry),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_pmp();
    pmpcfg  = '0;
    pmpaddr = '0;
  endtask

  task automatic set_entry(input int i, input logic [7:0] c, input logic [31:0] a);
    pmpcfg[8*i +: 8]   = c;
    pmpaddr[32*i +: 32] = a;
  endtask

  // Issues one request and completes the response handshake. lat is the
  // cycle number (edge 0 = acceptance) in which resp_valid was first seen.
  task automatic do_req(input logic [31:0] a, input logic [1:0] s,
                        input logic [1:0] t, input logic m,
                        output int lat, output logic al, output logic h,
                        output logic [3:0] e);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_type  = t;
    req_mmode = m;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    al = resp_allow;
    h  = resp_hit;
    e  = resp_entry;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_size = '0; req_type = '0; req_mmode = 1'b0;
    clear_pmp();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); else n_pass++;
    n_total++; if (resp_allow !== 1'b0) $display("FAIL reset_resp_allow got=%b exp=0", resp_allow); else n_pass++;
    n_total++; if (resp_hit !== 1'b0) $display("FAIL reset_resp_hit got=%b exp=0", resp_hit); else n_pass++;
    n_total++; if (resp_entry !== 4'd0) $display("FAIL reset_resp_entry got=%0d exp=0", resp_entry); else n_pass++;
    n_total++; if (dbg_state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); else n_pass++;
  endtask

  task automatic test_napot_hit();
    int lat; logic al, h; logic [3:0] e;
    clear_pmp();
    set_entry(0, 8'h19, 32'h0000_0FFF);   // NAPOT, R
    do_req(32'h10, 2'd3, 2'd0, 1'b0, lat, al, h, e);
    n_total++; if (h !== 1'b1) $display("FAIL napot_hit got=%b exp=1", h); else n_pass++;
    n_total++; if (e !== 4'd0) $display("FAIL napot_entry got=%0d exp=0", e); else n_pass++;
    n_total++; if (al !== 1'b1) $display("FAIL napot_allow got=%b exp=1", al); else n_pass++;
    n_total++; if (lat != 2) $display("FAIL napot_latency got=%0d exp=2", lat); else n_pass++;
  endtask

  task automatic test_tor_write_denied();
    int lat; logic al, h; logic [3:0] e;
    clear_pmp();
    set_entry(2, 8'h00, 32'h0000_1000);   // OFF, supplies TOR lower bound
    set_entry(3, 8'h09, 32'h0000_2000);   // TOR, R only
    do_req(32'h1800, 2'd3, 2'd1, 1'b0, lat, al, h, e);
    n_total++; if (h !== 1'b1) $display("FAIL tor_hit got=%b exp=1", h); else n_pass++;
    n_total++; if (e !== 4'd3) $display("FAIL tor_entry got=%0d exp=3", e); else n_pass++;
    n_total++; if (al !== 1'b0) $display("FAIL tor_allow got=%b exp=0", al); else n_pass++;
    n_total++; if (lat != 5) $display("FAIL tor_latency got=%0d exp=5", lat); else n_pass++;
  endtask

  task automatic test_no_match();
    int lat; logic al, h; logic [3:0] e;
    clear_pmp();
    do_req(32'h8000_0000, 2'd3, 2'd2, 1'b1, lat, al, h, e);
    n_total++; if (al !== 1'b1) $display("FAIL nomatch_m_allow got=%b exp=1", al); else n_pass++;
    n_total++; if (h !== 1'b0) $display("FAIL nomatch_m_hit got=%b exp=0", h); else n_pass++;
    n_total++; if (e !== 4'd0) $display("FAIL nomatch_m_entry got=%0d exp=0", e); else n_pass++;
    n_total++; if (lat != 17) $display("FAIL nomatch_latency got=%0d exp=17", lat); else n_pass++;
    // back-to-back: next request goes in the cycle after the handshake
    do_req(32'h0000_1234, 2'd0, 2'd0, 1'b0, lat, al, h, e);
    n_total++; if (al !== 1'b0) $display("FAIL nomatch_u_allow got=%b exp=0", al); else n_pass++;
    n_total++; if (h !== 1'b0) $display("FAIL nomatch_u_hit got=%b exp=0", h); else n_pass++;
    n_total++; if (lat != 17) $display("FAIL nomatch_u_latency got=%0d exp=17", lat); else n_pass++;
  endtask

  task automatic test_priority_lock();
    int lat; logic al, h; logic [3:0] e;
    clear_pmp();
    set_entry(1, 8'h9B, 32'h0000_02FF);   // NAPOT 0x200-0x2FF, R W, X=0, L=1
    set_entry(4, 8'h1C, 32'hFFFF_FFFF);   // NAPOT whole space, X
    do_req(32'h200, 2'd3, 2'd2, 1'b1, lat, al, h, e);
    n_total++; if (e !== 4'd1) $display("FAIL lock_entry got=%0d exp=1", e); else n_pass++;
    n_total++; if (al !== 1'b0) $display("FAIL lock_allow got=%b exp=0", al); else n_pass++;
    n_total++; if (lat != 3) $display("FAIL lock_latency got=%0d exp=3", lat); else n_pass++;
    set_entry(1, 8'h1B, 32'h0000_02FF);   // same entry, unlocked
    do_req(32'h200, 2'd3, 2'd2, 1'b1, lat, al, h, e);
    n_total++; if (e !== 4'd1) $display("FAIL unlock_entry got=%0d exp=1", e); else n_pass++;
    n_total++; if (al !== 1'b1) $display("FAIL unlock_allow got=%b exp=1", al); else n_pass++;
    // U-mode through the unlocked entry still obeys X=0
    do_req(32'h2F0, 2'd3, 2'd2, 1'b0, lat, al, h, e);
    n_total++; if (al !== 1'b0) $display("FAIL unlock_u_allow got=%b exp=0", al); else n_pass++;
  endtask

  task automatic test_boundary();
    int lat; logic al, h; logic [3:0] e;
    clear_pmp();
    set_entry(0, 8'h11, 32'h0000_0040);   // NA4 0x40-0x43, R
    set_entry(1, 8'h19, 32'hFFFF_FFFF);   // NAPOT whole space, R
    do_req(32'h40, 2'd3, 2'd0, 1'b0, lat, al, h, e);
    n_total++; if (h !== 1'b1 || e !== 4'd0) $display("FAIL na4_word hit=%b entry=%0d exp hit=1 entry=0", h, e); else n_pass++;
    do_req(32'h43, 2'd1, 2'd0, 1'b0, lat, al, h, e);
    n_total++; if (e !== 4'd1) $display("FAIL na4_partial_entry got=%0d exp=1", e); else n_pass++;
    n_total++; if (lat != 3) $display("FAIL na4_partial_latency got=%0d exp=3", lat); else n_pass++;
    // size 2 acts as a word: 0x41..0x44 straddles the NA4 region
    do_req(32'h41, 2'd2, 2'd0, 1'b0, lat, al, h, e);
    n_total++; if (e !== 4'd1) $display("FAIL size2_entry got=%0d exp=1", e); else n_pass++;
    clear_pmp();
    set_entry(0, 8'h09, 32'hFFFF_FFFF);   // TOR 0..0xFFFF_FFFE, R
    do_req(32'hFFFF_FFFE, 2'd3, 2'd0, 1'b0, lat, al, h, e);
    n_total++; if (h !== 1'b0) $display("FAIL tor_carry_hit got=%b exp=0", h); else n_pass++;
    n_total++; if (al !== 1'b0) $display("FAIL tor_carry_allow got=%b exp=0", al); else n_pass++;
  endtask

  task automatic test_handshake_hold();
    logic al0, h0; logic [3:0] e0;
    int cyc;
    int bad;
    clear_pmp();
    set_entry(2, 8'h1B, 32'h0000_0FFF);   // NAPOT 4 KiB, R W
    req_valid = 1'b1; req_addr = 32'h100; req_size = 2'd3; req_type = 2'd1; req_mmode = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_total++; if (cyc != 4) $display("FAIL hold_latency got=%0d exp=4", cyc); else n_pass++;
    al0 = resp_allow; h0 = resp_hit; e0 = resp_entry;
    n_total++; if (al0 !== 1'b1 || h0 !== 1'b1 || e0 !== 4'd2) $display("FAIL hold_fields allow=%b hit=%b entry=%0d exp 1 1 2", al0, h0, e0); else n_pass++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_allow !== al0 ||
          resp_hit !== h0 || resp_entry !== e0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL hold_stable unstable_cycles=%0d exp=0", bad); else n_pass++;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL hold_release valid=%b ready=%b exp 0 1", resp_valid, req_ready); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    clear_pmp();
    req_valid = 1'b1; req_addr = 32'h500; req_size = 2'd0; req_type = 2'd0; req_mmode = 1'b1;
    @(posedge clk); #1;                // cycle 1
    req_valid = 1'b0;
    @(posedge clk); #1;                // cycle 2
    @(posedge clk); #1;                // cycle 3
    n_total++; if (busy !== 1'b1) $display("FAIL midscan_busy got=%b exp=1", busy); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (dbg_state !== IDLE || req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL midscan_reset state=%0d ready=%b busy=%b valid=%b exp 0 1 0 0", dbg_state, req_ready, busy, resp_valid);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) seen++;
    end
    n_total++; if (seen != 0) $display("FAIL midscan_lost resp_valid_cycles=%0d exp=0", seen); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_napot_hit();
    test_tor_write_denied();
    test_no_match();
    test_priority_lock();
    test_boundary();
    test_handshake_hold();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
